// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, and
// press / release / long-press event generation with a clean level.
//
// state        | meaning
// -------------+---------------------------------------------------------
// IDLE         | button released and stable
// PRESS_WAIT   | input went high, counting stable-high cycles
// PRESSED      | press accepted, counting hold time toward a long press
// LONG         | long press reported, waiting for release
// RELEASE_WAIT | input went low, counting stable-low cycles
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES   = 1000000,
   parameter int LONG_PRESS_CYCLES = 200000000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic long_held
);

   localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES) + 1;

   // Counters hold "stable cycles seen so far"; the cycle that would make the
   // count reach its target is the one that triggers the transition, so the
   // registered event appears exactly DEBOUNCE / LONG_PRESS cycles later.
   localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      LONG,
      RELEASE_WAIT
   } state_t;

   state_t              r_state;
   logic                r_sync1;
   logic                r_sync2;
   logic [DEB_W-1:0]    r_deb_cnt;
   logic [HOLD_W-1:0]   r_hold_cnt;
   logic                r_ret_long;
   logic                r_btn_level;
   logic                r_press_pulse;
   logic                r_release_pulse;
   logic                r_long_pulse;
   logic                r_long_held;
   logic                w_sync_in;

   assign w_sync_in     = r_sync2;
   assign btn_level     = r_btn_level;
   assign press_pulse   = r_press_pulse;
   assign release_pulse = r_release_pulse;
   assign long_pulse    = r_long_pulse;
   assign long_held     = r_long_held;

   // Bring the asynchronous pad into the clk domain.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= btn_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Debounce / long-press FSM with registered level and event outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= IDLE;
         r_deb_cnt       <= '0;
         r_hold_cnt      <= '0;
         r_ret_long      <= 1'b0;
         r_btn_level     <= 1'b0;
         r_press_pulse   <= 1'b0;
         r_release_pulse <= 1'b0;
         r_long_pulse    <= 1'b0;
         r_long_held     <= 1'b0;
      end else begin
         r_press_pulse   <= 1'b0;
         r_release_pulse <= 1'b0;
         r_long_pulse    <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_sync_in) begin
                  r_state   <= PRESS_WAIT;
                  r_deb_cnt <= DEB_ONE;
               end
            end
            PRESS_WAIT: begin
               if (!w_sync_in) begin
                  r_state   <= IDLE;
                  r_deb_cnt <= '0;
               end else if (r_deb_cnt == DEB_LAST) begin
                  r_state       <= PRESSED;
                  r_deb_cnt     <= '0;
                  r_hold_cnt    <= '0;
                  r_btn_level   <= 1'b1;
                  r_press_pulse <= 1'b1;
               end else begin
                  r_deb_cnt <= r_deb_cnt + DEB_ONE;
               end
            end
            PRESSED: begin
               if (!w_sync_in) begin
                  // Release path wins over a coincident hold terminal count.
                  r_state    <= RELEASE_WAIT;
                  r_deb_cnt  <= DEB_ONE;
                  r_ret_long <= 1'b0;
               end else if (r_hold_cnt == HOLD_LAST) begin
                  r_state      <= LONG;
                  r_long_pulse <= 1'b1;
                  r_long_held  <= 1'b1;
               end else begin
                  r_hold_cnt <= r_hold_cnt + HOLD_ONE;
               end
            end
            LONG: begin
               if (!w_sync_in) begin
                  r_state    <= RELEASE_WAIT;
                  r_deb_cnt  <= DEB_ONE;
                  r_ret_long <= 1'b1;
               end
            end
            RELEASE_WAIT: begin
               if (w_sync_in) begin
                  // Glitch rejected: the high cycle that ends it counts as hold
                  // time, so only the low cycles are lost from the long count.
                  r_deb_cnt <= '0;
                  if (r_ret_long) begin
                     r_state <= LONG;
                  end else if (r_hold_cnt == HOLD_LAST) begin
                     r_state      <= LONG;
                     r_long_pulse <= 1'b1;
                     r_long_held  <= 1'b1;
                  end else begin
                     r_state    <= PRESSED;
                     r_hold_cnt <= r_hold_cnt + HOLD_ONE;
                  end
               end else if (r_deb_cnt == DEB_LAST) begin
                  r_state         <= IDLE;
                  r_deb_cnt       <= '0;
                  r_hold_cnt      <= '0;
                  r_btn_level     <= 1'b0;
                  r_long_held     <= 1'b0;
                  r_release_pulse <= 1'b1;
               end else begin
                  r_deb_cnt <= r_deb_cnt + DEB_ONE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios then random bouncing,
// checked against an accepted-level / run-length reference model.
module tb_button_conditioner;

   localparam int DEB  = 4;
   localparam int LONG = 10;

   logic clk;
   logic reset;
   logic btn_raw;
   logic btn_level;
   logic press_pulse;
   logic release_pulse;
   logic long_pulse;
   logic long_held;

   button_conditioner #(
      .DEBOUNCE_CYCLES   (DEB),
      .LONG_PRESS_CYCLES (LONG)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .btn_raw       (btn_raw),
      .btn_level     (btn_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_pulse    (long_pulse),
      .long_held     (long_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int kind;   // 0 press, 1 release, 2 long
      int cyc;
   } ev_t;

   ev_t q[$];
   int  cyc = 0;
   int  n_cmp = 0;
   int  n_err = 0;
   int  last_press = -1;
   int  last_release = -1;
   int  last_long = -1;

   // Reference model state: the synchronized input, the currently accepted
   // level, the length of the current run disagreeing with it, and the number
   // of high cycles accumulated since the press was accepted.
   logic m_s1 = 1'b0, m_s2 = 1'b0, m_acc = 1'b0, m_lng = 1'b0;
   int   m_run = 0, m_hold = 0;

   always @(posedge clk) begin
      logic sync;
      ev_t  e;
      cyc = cyc + 1;
      if (reset) begin
         m_s1 = 0; m_s2 = 0; m_acc = 0; m_lng = 0; m_run = 0; m_hold = 0;
      end else begin
         sync = m_s2;
         m_s2 = m_s1;
         m_s1 = btn_raw;
         if (sync != m_acc) begin
            m_run = m_run + 1;
            if (m_run == DEB) begin
               m_acc = sync;
               m_run = 0;
               m_hold = 0;
               if (!sync) m_lng = 0;
               e.kind = sync ? 0 : 1;
               e.cyc  = cyc;
               q.push_back(e);
            end
         end else begin
            m_run = 0;
            if (m_acc && !m_lng) begin
               m_hold = m_hold + 1;
               if (m_hold == LONG) begin
                  m_lng  = 1;
                  e.kind = 2;
                  e.cyc  = cyc;
                  q.push_back(e);
               end
            end
         end
      end
   end

   // Monitor: compare levels every cycle, match pulses against the queue.
   always @(negedge clk) begin
      int  kind;
      int  npulse;
      ev_t e;
      n_cmp = n_cmp + 1;
      if (btn_level !== m_acc) begin
         n_err = n_err + 1;
         $display("FAIL level cyc=%0d got=%b want=%b", cyc, btn_level, m_acc);
      end
      n_cmp = n_cmp + 1;
      if (long_held !== m_lng) begin
         n_err = n_err + 1;
         $display("FAIL long_held cyc=%0d got=%b want=%b", cyc, long_held, m_lng);
      end
      while (q.size() > 0 && q[0].cyc < cyc) begin
         e = q.pop_front();
         n_cmp = n_cmp + 1;
         n_err = n_err + 1;
         $display("FAIL missed_event cyc=%0d got=none want=kind%0d@%0d", cyc, e.kind, e.cyc);
      end
      npulse = int'(press_pulse === 1'b1) + int'(release_pulse === 1'b1) + int'(long_pulse === 1'b1);
      if (npulse > 1) begin
         n_cmp = n_cmp + 1;
         n_err = n_err + 1;
         $display("FAIL multi_pulse cyc=%0d got=%0d want=1", cyc, npulse);
      end
      if (npulse > 0) begin
         kind = press_pulse ? 0 : (release_pulse ? 1 : 2);
         if (kind == 0) last_press = cyc;
         if (kind == 1) last_release = cyc;
         if (kind == 2) last_long = cyc;
         n_cmp = n_cmp + 1;
         if (q.size() == 0) begin
            n_err = n_err + 1;
            $display("FAIL extra_event cyc=%0d got=kind%0d want=none", cyc, kind);
         end else begin
            e = q.pop_front();
            if (e.kind != kind || e.cyc != cyc) begin
               n_err = n_err + 1;
               $display("FAIL event cyc=%0d got=kind%0d@%0d want=kind%0d@%0d",
                        cyc, kind, cyc, e.kind, e.cyc);
            end
         end
      end
   end

   task automatic step(input logic v, input int n);
      btn_raw = v;
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic check_eq(input string name, input int got, input int want);
      n_cmp = n_cmp + 1;
      if (got != want) begin
         n_err = n_err + 1;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   initial begin
      int t0;
      reset   = 1'b1;
      btn_raw = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      step(0, 3);

      // Clean long press and release.
      t0 = cyc;
      step(1, 30);
      check_eq("clean_press_time", last_press, t0 + 2 + DEB);
      check_eq("long_time", last_long, last_press + LONG);
      t0 = cyc;
      step(0, 12);
      check_eq("release_time", last_release, t0 + 2 + DEB);

      // Bouncing press.
      step(1, 1); step(0, 1); step(1, 1); step(0, 1);
      t0 = cyc;
      step(1, 12);
      check_eq("bounce_press_time", last_press, t0 + 2 + DEB);
      step(0, 12);

      // Release glitch during the hold count.
      t0 = cyc;
      step(1, 11);
      step(0, 2);
      step(1, 25);
      check_eq("glitch_long_time", last_long, last_press + LONG + 2);
      step(0, 12);

      // Short press.
      t0 = last_long;
      step(1, 12);
      step(0, 12);
      check_eq("short_no_long", last_long, t0);

      // Reset mid-debounce with button held.
      step(1, 5);
      reset = 1'b1;
      step(1, 2);
      reset = 1'b0;
      t0 = cyc;
      step(1, 14);
      check_eq("reset_press_time", last_press, t0 + 2 + DEB);
      step(0, 12);

      // Random bouncing with occasional reset.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            reset = 1'b1;
            step(btn_raw, $urandom_range(1, 3));
            reset = 1'b0;
         end
         if ($urandom_range(0, 2) == 0)
            step(1'($urandom_range(0, 1)), $urandom_range(5, 25));
         else
            step(1'($urandom_range(0, 1)), $urandom_range(1, 4));
      end

      step(0, 20);
      check_eq("queue_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
